// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and presents {instr, npc, valid} to the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] tgt_reg;
  logic [31:0] hold_instr_reg;
  logic [31:0] hold_npc_reg;
  logic [31:0] instr_reg;
  logic [31:0] npc_reg;
  logic        valid_reg;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

  // WAIT and DRAIN keep the request up so the address stays stable until ack.
  assign imem_req  = ((state_reg == S_FETCH) && !stall && !redirect) ||
                     (state_reg == S_WAIT) || (state_reg == S_DRAIN);
  assign imem_addr = pc_reg;

  assign instr = instr_reg;
  assign npc   = npc_reg;
  assign valid = valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      npc_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else if (redirect) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
      // An unfinished fetch must still complete on its old address before
      // the new target can be issued.
      if (((state_reg == S_WAIT) || (state_reg == S_DRAIN)) && !imem_ack) begin
        tgt_reg   <= redirect_pc;
        state_reg <= S_DRAIN;
      end else begin
        pc_reg    <= redirect_pc;
        state_reg <= S_FETCH;
      end
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (!stall) begin
            if (imem_ack) begin
              instr_reg <= imem_rdata;
              npc_reg   <= pc_plus4;
              valid_reg <= 1'b1;
              pc_reg    <= pc_plus4;
            end else begin
              instr_reg <= NOP_INSTR;
              valid_reg <= 1'b0;
              state_reg <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            pc_reg <= pc_plus4;
            if (!stall) begin
              instr_reg <= imem_rdata;
              npc_reg   <= pc_plus4;
              valid_reg <= 1'b1;
              state_reg <= S_FETCH;
            end else begin
              hold_instr_reg <= imem_rdata;
              hold_npc_reg   <= pc_plus4;
              state_reg      <= S_HOLD;
            end
          end else if (!stall) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_reg <= hold_instr_reg;
            npc_reg   <= hold_npc_reg;
            valid_reg <= 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            pc_reg    <= tgt_reg;
            state_reg <= S_FETCH;
          end
          if (!stall) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
          end
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage against a transaction-level fetch model
// (outstanding fetch / squash flag / one parked word).
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .npc(npc),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference model: what the fetch unit is doing in transaction terms.
  logic        m_known = 1'b0;
  logic [31:0] m_pc;
  logic        m_inflight;
  logic        m_squash;
  logic [31:0] m_tgt;
  logic        m_parked;
  logic [31:0] m_park_instr, m_park_npc;
  logic [31:0] m_instr, m_npc;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_req(input logic s, input logic r);
    return m_inflight || (!m_parked && !s && !r);
  endfunction

  task automatic model_step(input logic r_rst, input logic s, input logic r,
                            input logic [31:0] rpc, input logic ack, input logic [31:0] data);
    logic req;
    req = model_req(s, r);
    if (r_rst) begin
      m_known = 1'b1; m_pc = RESET_PC; m_inflight = 1'b0; m_squash = 1'b0;
      m_parked = 1'b0; m_instr = NOP_INSTR; m_npc = 32'd0; m_valid = 1'b0;
    end else if (r) begin
      m_instr = NOP_INSTR; m_valid = 1'b0; m_parked = 1'b0;
      if (m_inflight && !ack) begin
        m_squash = 1'b1; m_tgt = rpc;
      end else begin
        m_pc = rpc; m_inflight = 1'b0; m_squash = 1'b0;
      end
    end else if (m_parked) begin
      if (!s) begin
        m_instr = m_park_instr; m_npc = m_park_npc; m_valid = 1'b1; m_parked = 1'b0;
      end
    end else if (req) begin
      if (ack) begin
        m_inflight = 1'b0;
        if (m_squash) begin
          m_squash = 1'b0; m_pc = m_tgt;
          if (!s) begin m_instr = NOP_INSTR; m_valid = 1'b0; end
        end else if (s) begin
          m_parked = 1'b1; m_park_instr = data; m_park_npc = m_pc + 32'd4;
          m_pc = m_pc + 32'd4;
        end else begin
          m_instr = data; m_npc = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end else begin
        m_inflight = 1'b1;
        if (!s) begin m_instr = NOP_INSTR; m_valid = 1'b0; end
      end
    end
  endtask

  // One clock: drive controls, check request side, answer it, check outputs.
  task automatic cycle(input logic r_rst, input logic s, input logic r,
                       input logic [31:0] rpc, input int ack_pct);
    logic exp_req;
    logic a;
    @(negedge clk);
    rst = r_rst; stall = s; redirect = r; redirect_pc = rpc;
    #1;
    exp_req = 1'b0;
    if (m_known) begin
      exp_req = model_req(s, r);
      check_val("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) check_val("imem_addr", imem_addr, m_pc);
    end
    a = exp_req && ($urandom_range(99) < ack_pct);
    imem_ack = a;
    imem_rdata = a ? mem_word(m_pc) : $urandom;
    @(posedge clk);
    model_step(r_rst, s, r, rpc, a, imem_rdata);
    #1;
    check_val("valid", {31'd0, valid}, {31'd0, m_valid});
    check_val("instr", instr, m_instr);
    check_val("npc", npc, m_npc);
    if (m_valid && !s && !r && !r_rst && valid) begin
      delivered++;
      $display("deliver #%0d instr=%08h npc=%08h t=%0t", delivered, instr, npc, $time);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return {$urandom_range(32'h3FF), 2'b00};
  endfunction

  initial begin
    // Reset then zero-wait stream: expect npc 4,8,C,10.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 100);
    check_val("reset_npc", npc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 100);
      check_val("stream_npc", npc, 32'd4 * (i + 1));
    end
    // Redirect near the top of the address space to exercise PC wrap.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 100);

    // Random phases: {ack %, stall %, redirect %, reset %}.
    for (int ph = 0; ph < 4; ph++) begin
      int ack_pct, st_pct, rd_pct, rs_pct;
      case (ph)
        0: begin ack_pct = 40;  st_pct = 0;  rd_pct = 0;  rs_pct = 0; end
        1: begin ack_pct = 50;  st_pct = 40; rd_pct = 0;  rs_pct = 0; end
        2: begin ack_pct = 35;  st_pct = 30; rd_pct = 20; rs_pct = 0; end
        default: begin ack_pct = 50; st_pct = 30; rd_pct = 15; rs_pct = 3; end
      endcase
      for (int i = 0; i < 300; i++) begin
        cycle($urandom_range(99) < rs_pct, $urandom_range(99) < st_pct,
              $urandom_range(99) < rd_pct, rand_pc(), ack_pct);
      end
    end

    // Reset while a fetch is outstanding.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
    check_val("rst_mid_wait_valid", {31'd0, valid}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
